// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the single-clock FIFO.
package fifo_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 512;
  localparam int AEMPTY_TH_DEF = 4;

  // One extra bit so pointers carry a wrap flag and count can reach DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one write port, one registered read port; the array itself is never reset.
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              r_en,
  input  logic [AW-1:0]     r_addr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= d_in;
  end

  // Read register holds its value between reads so q never goes to X once reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (r_en) q <= mem[r_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO: pointers, registered count, threshold flags and sticky errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_W-1:0]       d_in,
  input  logic                    r_en,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic                    f_full,
  output logic                    f_empty,
  output logic                    f_afull,
  output logic                    f_aempty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = CW - 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 4");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull
    $error("sync_fifo: AFULL_TH out of range 1..DEPTH-1");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 2) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_TH out of range 0..DEPTH-2");
  end

  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic          r_acc;
  logic          w_acc;

  assign f_full   = (count == CW'(DEPTH));
  assign f_empty  = (count == '0);
  assign f_afull  = (count >= CW'(AFULL_TH));
  assign f_aempty = (count <= CW'(AEMPTY_TH));

  // A full FIFO still takes a write when a read drains a slot on the same edge.
  assign r_acc = r_en && !f_empty;
  assign w_acc = w_en && (!f_full || r_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) rptr <= rptr + 1'b1;
      case ({w_acc, r_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      data_valid <= r_acc;
      overflow   <= (w_en && !w_acc) || (overflow && !clr_err);
      underflow  <= (r_en && f_empty) || (underflow && !clr_err);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_acc),
    .w_addr (wptr[AW-1:0]),
    .d_in   (d_in),
    .r_en   (r_acc),
    .r_addr (rptr[AW-1:0]),
    .q      (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DEPTH=16 with hand-computed expectations.
module tb_sync_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              w_en = 1'b0;
  logic [DATA_W-1:0] d_in = '0;
  logic              r_en = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              f_full, f_empty, f_afull, f_aempty;
  logic [4:0]        count;
  logic              overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (12),
    .AEMPTY_TH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .d_in       (d_in),
    .r_en       (r_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .f_full     (f_full),
    .f_empty    (f_empty),
    .f_afull    (f_afull),
    .f_aempty   (f_aempty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst data_out", data_out, 0);
    chk("rst data_valid", 32'(data_valid), 0);
    chk("rst count", 32'(count), 0);
    chk("rst f_empty", 32'(f_empty), 1);
    chk("rst f_aempty", 32'(f_aempty), 1);
    chk("rst f_full", 32'(f_full), 0);
    chk("rst f_afull", 32'(f_afull), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst underflow", 32'(underflow), 0);
    step();
    rst = 1'b0;

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      w_en = 1'b1;
      d_in = 32'(i);
      step();
      chk("fill count", 32'(count), 32'(i));
      chk("fill f_afull", 32'(f_afull), (i >= 12) ? 1 : 0);
      chk("fill f_full", 32'(f_full), (i == 16) ? 1 : 0);
      chk("fill f_aempty", 32'(f_aempty), (i <= 4) ? 1 : 0);
    end
    w_en = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      r_en = 1'b1;
      step();
      chk("drain data", data_out, 32'(i));
      chk("drain valid", 32'(data_valid), 1);
      chk("drain f_aempty", 32'(f_aempty), (16 - i <= 4) ? 1 : 0);
    end
    r_en = 1'b0;
    step();
    chk("drain valid low", 32'(data_valid), 0);
    chk("drain f_empty", 32'(f_empty), 1);
    chk("drain hold data", data_out, 32'h10);

    // Full, then 40 cycles of simultaneous read/write across pointer wrap
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1;
      d_in = 32'h100 + 32'(i);
      step();
    end
    chk("refill full", 32'(f_full), 1);
    for (int k = 0; k < 40; k++) begin
      w_en = 1'b1;
      r_en = 1'b1;
      d_in = 32'h200 + 32'(k);
      step();
      chk("rw data", data_out, (k < 16) ? 32'h100 + 32'(k) : 32'h200 + 32'(k - 16));
      chk("rw count", 32'(count), 16);
    end
    chk("rw overflow", 32'(overflow), 0);

    // Write while full is dropped
    r_en = 1'b0;
    w_en = 1'b1;
    d_in = 32'hDEAD;
    step();
    w_en = 1'b0;
    chk("ovf flag", 32'(overflow), 1);
    chk("ovf count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      r_en = 1'b1;
      step();
      chk("ovf drain data", data_out, 32'h218 + 32'(i));
    end
    r_en = 1'b0;
    chk("ovf sticky", 32'(overflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf cleared", 32'(overflow), 0);

    // Empty with simultaneous request: write taken, read rejected
    w_en = 1'b1;
    r_en = 1'b1;
    d_in = 32'hA5;
    step();
    w_en = 1'b0;
    chk("udf count", 32'(count), 1);
    chk("udf valid", 32'(data_valid), 0);
    chk("udf flag", 32'(underflow), 1);
    step();
    r_en = 1'b0;
    chk("udf read data", data_out, 32'hA5);
    chk("udf read valid", 32'(data_valid), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("udf cleared", 32'(underflow), 0);

    // Async reset mid-operation
    for (int i = 0; i < 10; i++) begin
      w_en = 1'b1;
      d_in = 32'h300 + 32'(i);
      step();
    end
    w_en = 1'b0;
    chk("pre-rst count", 32'(count), 10);
    #3 rst = 1'b1;
    #1;
    chk("async rst count", 32'(count), 0);
    chk("async rst f_empty", 32'(f_empty), 1);
    chk("async rst data_out", data_out, 0);
    #1 rst = 1'b0;
    w_en = 1'b1;
    d_in = 32'h77;
    step();
    w_en = 1'b0;
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    chk("post-rst data", data_out, 32'h77);
    chk("post-rst valid", 32'(data_valid), 1);
    chk("post-rst count", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO that succeeds the fixed 32×512 FIFO memory: configurable width and depth, internal pointer management, registered read data with a valid strobe, fill count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a producer and consumer in the same clock domain. It is also the storage and control core reused by the verification environment's single-clock reference model.

## Interface
Parameters:
- DATA_W, 32, data word width in bits (≥1)
- DEPTH, 512, number of entries; power of two, ≥4
- AFULL_TH, DEPTH-4, f_afull asserts when count ≥ AFULL_TH (1..DEPTH-1)
- AEMPTY_TH, 4, f_aempty asserts when count ≤ AEMPTY_TH (0..DEPTH-2)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- w_en  in  1  write request
- d_in  in  DATA_W  write data, sampled with w_en
- r_en  in  1  read request
- data_out  out  DATA_W  registered read data
- data_valid  out  1  data_out holds a newly read word this cycle
- f_full  out  1  count == DEPTH
- f_empty  out  1  count == 0
- f_afull  out  1  count ≥ AFULL_TH
- f_aempty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full and not accepted
- underflow  out  1  sticky: read requested while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Pointers wptr/rptr are $clog2(DEPTH)+1 bits; low bits address storage, MSB is the wrap bit. Both increment modulo 2·DEPTH.
- r_acc = r_en && !f_empty.
- w_acc = w_en && (!f_full || r_acc). A write while full is accepted when a read is accepted in the same cycle.
- On r_acc: data_out ← mem[rptr], data_valid ← 1, rptr increments. Otherwise data_valid ← 0 and data_out holds its last value (never driven to X).
- On w_acc: mem[wptr] ← d_in, wptr increments.
- count is registered: +1 on w_acc only, −1 on r_acc only, unchanged on both or neither.
- Flags are decoded from registered count and are valid in the same cycle as count.
- Empty with w_en && r_en: the write is accepted and the read is rejected (no bypass). underflow sets.
- overflow sets on w_en && !w_acc. underflow sets on r_en && f_empty. Both hold until clr_err or rst. If clr_err and a new error coincide, the set wins.
- Storage is not reset. Contents are undefined until written.

## Timing
- Reset values: data_out 0, data_valid 0, count 0, f_empty 1, f_aempty 1, f_full 0, f_afull 0 (given legal AFULL_TH ≥ 1), overflow 0, underflow 0. Pointers are 0.
- Reset mid-operation empties the FIFO immediately and asynchronously. Requests in the cycle rst deasserts are honoured at the first clock edge with rst low.
- Read latency is 1: data_out/data_valid update on the edge after r_acc is sampled.
- Write-to-read latency is 1: a word written at edge N is readable via r_en at edge N+1. f_empty deasserts after edge N.
- Flags and count update on the edge that accepts the transaction and are never combinational from w_en/r_en.
- Sustained simultaneous read/write holds count constant indefinitely, including at count == DEPTH.

## Structure
- Package fifo_pkg holds the default parameter values and a function cnt_w(depth) = $clog2(depth)+1 used for count/pointer widths.
- Sub-module fifo_ram holds the DEPTH×DATA_W storage: one write port, one synchronous read port, no reset on the array.
- sync_fifo holds pointers, count, flags, error logic and the data_valid register.
- Elaboration-time assertions check that DEPTH is a power of two and ≥4, and that the thresholds are in range.

## Test plan
Bench parameters: DATA_W=32, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4.
- Reset, then write 0x1..0x10 (16 words) → count 16, f_full=1, f_afull first high after the 12th write. Read 16 → data_out 0x1..0x10 in order, each 1 cycle after r_en, data_valid pulsing. f_empty=1 at end.
- Full, then 40 cycles of w_en&&r_en with d_in incrementing → count stays 16, overflow=0, read order continuous across pointer wrap.
- Full, then w_en alone with 0xDEAD → write dropped, overflow=1. Read all 16 → 0xDEAD never appears. clr_err → overflow=0.
- Empty, then w_en&&r_en with 0xA5 → count 1, data_valid=0, underflow=1. Next cycle r_en → data_out 0xA5.
- Write 10 words, assert rst asynchronously mid-cycle → count=0, f_empty=1, data_out=0 immediately. Next write 0x77 then read → data_out 0x77.
